// File: rtl/uart_sram_pkg.sv
// Shared constants for the UART SRAM responder: register selects, STATUS/CTRL bit
// positions and the CTRL reset value.
package uart_sram_pkg;

    typedef enum logic [1:0] {
        REG_TXDATA = 2'd0,
        REG_RXDATA = 2'd1,
        REG_STATUS = 2'd2,
        REG_CTRL   = 2'd3
    } reg_sel_e;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_EMPTY   = 2;
    localparam int ST_RX_FULL    = 3;
    localparam int ST_RX_OVERRUN = 4;
    localparam int ST_TX_OVFL    = 5;
    localparam int ST_TX_CNT     = 8;
    localparam int ST_RX_CNT     = 16;

    localparam int CT_TX_EN = 0;
    localparam int CT_RX_EN = 1;
    localparam int CT_RXIE  = 2;
    localparam int CT_TXIE  = 3;

    localparam logic [3:0] CTRL_RST = 4'b0011;

endpackage

// File: rtl/uart_sram64_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is read combinationally from storage.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, rptr_q;
    logic             push_ok, pop_ok;

    assign count_o = wptr_q - rptr_q;
    assign full_o  = (count_o == (AW+1)'(DEPTH));
    assign empty_o = (wptr_q == rptr_q);
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    // Acceptance uses pre-edge full/empty: a push to a full FIFO is refused even
    // when a pop frees a slot in the same cycle.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/uart_sram64.sv
// Memory-mapped UART responder: TX/RX byte FIFOs between the CPU SRAM port and the PHY.
// Optional interrupt output enabled by defining UART_SRAM_IRQ_EN.
module uart_sram64
    import uart_sram_pkg::*;
#(
    parameter int LEN_ADDR = 64,
    parameter int LEN_DATA = 64,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LEN_ADDR-1:0]   addra,
    input  logic [LEN_DATA-1:0]   dina,
    output logic [LEN_DATA-1:0]   douta,
    input  logic                  ena,
    input  logic [LEN_DATA/8-1:0] wea,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_ready
`ifdef UART_SRAM_IRQ_EN
    ,output logic                 irq
`endif
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);

`ifdef UART_SRAM_IRQ_EN
    localparam logic [3:0] CTRL_WMASK = 4'hF;
`else
    localparam logic [3:0] CTRL_WMASK = 4'h3;
`endif

    reg_sel_e            sel;
    logic                rd, wr;
    logic [LEN_DATA-1:0] douta_q, douta_d, rdata;
    logic [3:0]          ctrl_q, ctrl_d;
    logic                tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d;
    logic [31:0]         status;

    logic                tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]          tx_head;
    logic [TAW:0]        tx_cnt;
    logic                rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]          rx_head;
    logic [RAW:0]        rx_cnt;

    logic unused_bits;
    assign unused_bits = ^{addra[LEN_ADDR-1:5], addra[2:0], dina[LEN_DATA-1:8]};

    assign sel = reg_sel_e'(addra[4:3]);
    assign rd  = ena & ~(|wea);
    assign wr  = ena & (|wea);

    assign tx_push  = wr & wea[0] & (sel == REG_TXDATA);
    assign tx_valid = ctrl_q[CT_TX_EN] & ~tx_empty;
    assign tx_pop   = tx_valid & tx_ready;
    assign tx_data  = tx_head;

    assign rx_push = rx_ready & ctrl_q[CT_RX_EN];
    assign rx_pop  = rd & (sel == REG_RXDATA) & ~rx_empty;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push_i(tx_push), .pop_i(tx_pop), .din_i(dina[7:0]),
        .head_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_cnt)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push_i(rx_push), .pop_i(rx_pop), .din_i(rx_data),
        .head_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_cnt)
    );

    always_comb begin
        status                 = '0;
        status[ST_TX_FULL]     = tx_full;
        status[ST_TX_EMPTY]    = tx_empty;
        status[ST_RX_EMPTY]    = rx_empty;
        status[ST_RX_FULL]     = rx_full;
        status[ST_RX_OVERRUN]  = rx_ovr_q;
        status[ST_TX_OVFL]     = tx_ovf_q;
        status[ST_TX_CNT+:8]   = 8'(tx_cnt);
        status[ST_RX_CNT+:8]   = 8'(rx_cnt);

        rdata = '0;
        case (sel)
            REG_RXDATA: if (!rx_empty) rdata[8:0] = {1'b1, rx_head};
            REG_STATUS: rdata[31:0] = status;
            REG_CTRL:   rdata[3:0]  = ctrl_q;
            default:    rdata = '0;
        endcase
        douta_d = rd ? rdata : douta_q;

        ctrl_d = ctrl_q;
        if (wr && wea[0] && sel == REG_CTRL) ctrl_d = dina[3:0] & CTRL_WMASK;

        // W1C first, then this cycle's set, so a coincident set wins.
        tx_ovf_d = tx_ovf_q;
        rx_ovr_d = rx_ovr_q;
        if (wr && wea[0] && sel == REG_STATUS) begin
            if (dina[ST_TX_OVFL])    tx_ovf_d = 1'b0;
            if (dina[ST_RX_OVERRUN]) rx_ovr_d = 1'b0;
        end
        if (tx_push && tx_full) tx_ovf_d = 1'b1;
        if (rx_push && rx_full) rx_ovr_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            douta_q  <= '0;
            ctrl_q   <= CTRL_RST;
            tx_ovf_q <= 1'b0;
            rx_ovr_q <= 1'b0;
        end else begin
            douta_q  <= douta_d;
            ctrl_q   <= ctrl_d;
            tx_ovf_q <= tx_ovf_d;
            rx_ovr_q <= rx_ovr_d;
        end
    end

    assign douta = douta_q;

`ifdef UART_SRAM_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= (ctrl_q[CT_RXIE] & ~rx_empty) | (ctrl_q[CT_TXIE] & tx_empty) | rx_ovr_q;
    end
    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_uart_sram64.sv
// Directed + randomized bench for uart_sram64 against a queue-based register model.
module tb_uart_sram64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] addra = '0;
    logic [63:0] dina = '0;
    logic [63:0] douta;
    logic        ena = 1'b0;
    logic [7:0]  wea = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_ready = 1'b0;
`ifdef UART_SRAM_IRQ_EN
    logic        irq;
    localparam logic [3:0] CMASK = 4'hF;
`else
    localparam logic [3:0] CMASK = 4'h3;
`endif

    always #5 clk = ~clk;

    uart_sram64 dut (
        .clk(clk), .rst(rst), .addra(addra), .dina(dina), .douta(douta), .ena(ena), .wea(wea),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_ready(rx_ready)
`ifdef UART_SRAM_IRQ_EN
        , .irq(irq)
`endif
    );

    // Reference model
    byte unsigned txq[$];
    byte unsigned rxq[$];
    bit          m_txovf, m_rxovr, m_irq;
    bit [3:0]    m_ctrl;
    logic [63:0] m_dout;
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] m_status();
        logic [63:0] s;
        s = 0;
        s = s | 64'(txq.size() == 16) | (64'(txq.size() == 0) << 1)
              | (64'(rxq.size() == 0) << 2) | (64'(rxq.size() == 16) << 3)
              | (64'(m_rxovr) << 4) | (64'(m_txovf) << 5)
              | (64'(txq.size()) << 8) | (64'(rxq.size()) << 16);
        return s;
    endfunction

    task automatic m_reset();
        txq.delete(); rxq.delete();
        m_txovf = 0; m_rxovr = 0; m_irq = 0; m_ctrl = 4'b0011; m_dout = 0;
    endtask

    // One clock: drive at negedge, predict from pre-edge model, check #1 after posedge.
    task automatic step(input logic e, input logic [7:0] w, input logic [63:0] a,
                        input logic [63:0] d, input logic txr, input logic rxr, input logic [7:0] rxd);
        int  sel;
        bit  rd, wr, tx_pop, tx_acc, rx_pop, rx_acc, irq_n;
        byte unsigned tb_byte;
        ena = e; wea = w; addra = a; dina = d; tx_ready = txr; rx_ready = rxr; rx_data = rxd;
        sel = int'(a[4:3]);
        rd = e && (w == 0);
        wr = e && (w != 0);
        irq_n = (m_ctrl[2] && rxq.size() > 0) || (m_ctrl[3] && txq.size() == 0) || m_rxovr;
        if (rd) begin
            case (sel)
                1: m_dout = (rxq.size() > 0) ? (64'h100 + 64'(rxq[0])) : 64'h0;
                2: m_dout = m_status();
                3: m_dout = 64'(m_ctrl);
                default: m_dout = 0;
            endcase
        end
        tx_pop = m_ctrl[0] && txq.size() > 0 && txr;
        tx_acc = wr && w[0] && sel == 0 && txq.size() < 16;
        rx_pop = rd && sel == 1 && rxq.size() > 0;
        rx_acc = rxr && m_ctrl[1] && rxq.size() < 16;
        if (wr && w[0] && sel == 2) begin
            if (d[5]) m_txovf = 0;
            if (d[4]) m_rxovr = 0;
        end
        if (wr && w[0] && sel == 0 && txq.size() == 16) m_txovf = 1;
        if (rxr && m_ctrl[1] && rxq.size() == 16) m_rxovr = 1;
        if (wr && w[0] && sel == 3) m_ctrl = d[3:0] & CMASK;
        if (tx_pop) tb_byte = txq.pop_front();
        if (tx_acc) txq.push_back(d[7:0]);
        if (rx_pop) tb_byte = rxq.pop_front();
        if (rx_acc) rxq.push_back(rxd);
        m_irq = irq_n;
        @(posedge clk);
        #1;
        chk("douta", douta, m_dout);
        chk("tx_valid", 64'(tx_valid), 64'(m_ctrl[0] && txq.size() > 0));
        if (m_ctrl[0] && txq.size() > 0) chk("tx_data", 64'(tx_data), 64'(txq[0]));
`ifdef UART_SRAM_IRQ_EN
        chk("irq", 64'(irq), 64'(m_irq));
`endif
        @(negedge clk);
        ena = 0; wea = 0; tx_ready = 0; rx_ready = 0;
    endtask

    task automatic rd_reg(input logic [63:0] a);  step(1, 8'h00, a, 0, 0, 0, 0); endtask
    task automatic wr_reg(input logic [63:0] a, input logic [63:0] d); step(1, 8'h01, a, d, 0, 0, 0); endtask

    initial begin
        m_reset();
        repeat (2) @(negedge clk);
        rst = 0;
        chk("reset_douta", douta, 64'h0);
        chk("reset_tx_valid", 64'(tx_valid), 64'h0);

        rd_reg(64'h10);
        chk("status_reset", douta, 64'h6);

        wr_reg(64'h0, 64'h41);
        wr_reg(64'h0, 64'h42);
        chk("tx_head_41", {56'h0, tx_data}, 64'h41);
        rd_reg(64'h10);
        chk("tx_count_2", 64'(douta[15:8]), 64'd2);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("tx_head_42", {56'h0, tx_data}, 64'h42);
        rd_reg(64'h10);
        chk("tx_count_1", 64'(douta[15:8]), 64'd1);
        step(0, 0, 0, 0, 1, 0, 0);

        for (int i = 0; i < 17; i++) wr_reg(64'h0, 64'(i + 8'h30));
        rd_reg(64'h10);
        chk("tx_ovf_set", 64'(douta[5]), 64'd1);
        chk("tx_full_cnt", 64'(douta[15:8]), 64'd16);
        wr_reg(64'h10, 64'h20);
        rd_reg(64'h10);
        chk("tx_ovf_w1c", 64'(douta[5]), 64'd0);
        chk("tx_cnt_kept", 64'(douta[15:8]), 64'd16);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 1, 0, 0);

        step(0, 0, 0, 0, 0, 1, 8'h55);
        step(0, 0, 0, 0, 0, 1, 8'hAA);
        rd_reg(64'h8);  chk("rx_55", douta, 64'h155);
        rd_reg(64'h8);  chk("rx_AA", douta, 64'h1AA);
        rd_reg(64'h8);  chk("rx_empty", douta, 64'h0);

        step(0, 0, 0, 0, 0, 1, 8'h11);
        step(1, 8'h00, 64'h8, 0, 0, 1, 8'h77);
        chk("rx_same_old", douta, 64'h111);
        rd_reg(64'h10);
        chk("rx_same_cnt", 64'(douta[23:16]), 64'd1);
        rd_reg(64'h8);  chk("rx_same_new", douta, 64'h177);

        for (int i = 0; i < 17; i++) step(0, 0, 0, 0, 0, 1, 8'(i));
        rd_reg(64'h10);
        chk("rx_overrun", 64'(douta[4]), 64'd1);
        wr_reg(64'h10, 64'h10);
        for (int i = 0; i < 16; i++) rd_reg(64'h8);

        wr_reg(64'h0, 64'h99);
        wr_reg(64'h18, 64'h0);
        chk("tx_stall", 64'(tx_valid), 64'd0);
        step(0, 0, 0, 0, 1, 1, 8'h12);
        step(0, 0, 0, 0, 1, 1, 8'h34);
        rd_reg(64'h10);
        chk("ctrl0_status", douta, 64'h104);
        wr_reg(64'h18, 64'h3);
        chk("tx_resume", {56'h0, tx_data}, 64'h99);

        for (int n = 0; n < 800; n++) begin
            int op;
            logic [63:0] a, d;
            logic [7:0] w;
            op = $urandom_range(0, 19);
            a = {$urandom, $urandom};
            d = {$urandom, $urandom};
            w = 8'($urandom_range(1, 255));
            case (op)
                0,1,2,3,4,5: begin a[4:3] = 0; step(1, w, a, d, ($urandom % 3) == 0, ($urandom % 3) == 0, 8'($urandom)); end
                6,7,8,9,10: begin a[4:3] = 1; step(1, 0, a, d, ($urandom % 2) == 0, ($urandom % 3) == 0, 8'($urandom)); end
                11,12,13: begin a[4:3] = 2; step(1, 0, a, d, ($urandom % 2) == 0, ($urandom % 2) == 0, 8'($urandom)); end
                14: begin a[4:3] = 2; step(1, w, a, d, ($urandom % 2) == 0, ($urandom % 2) == 0, 8'($urandom)); end
                15: begin a[4:3] = 3; if ($urandom_range(0, 3) != 0) d[1:0] = 2'b11; step(1, w, a, d, 0, 1, 8'($urandom)); end
                16: begin a[4:3] = 3; step(1, 0, a, d, 1, 0, 0); end
                17: begin a[4:3] = 1; step(1, w, a, d, 1, 1, 8'($urandom)); end
                default: step(0, 0, a, d, ($urandom % 2) == 0, ($urandom % 2) == 0, 8'($urandom));
            endcase
        end

        wr_reg(64'h18, 64'h3);
        wr_reg(64'h0, 64'hC3);
        step(0, 0, 0, 0, 0, 1, 8'h5A);
        rd_reg(64'h10);
        tx_ready = 1'b1;
        #3 rst = 1'b1;
        #1;
        chk("midrst_douta", douta, 64'h0);
        chk("midrst_tx_valid", 64'(tx_valid), 64'h0);
        m_reset();
        @(negedge clk);
        tx_ready = 1'b0;
        rst = 1'b0;
        rd_reg(64'h10);
        chk("midrst_status", douta, 64'h6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
